// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and widths for the register-file writeback arbiter
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int STARVE_W   = 4;

    typedef enum logic {
        PRIO_LSU = 1'b0,
        PRIO_ALU = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // A request only counts as a transfer once its grant is also present.
    function automatic wb_req_t gate_req(logic grant, wb_req_t req);
        wb_req_t r;
        r       = req;
        r.valid = req.valid & grant;
        return r;
    endfunction

endpackage

// File: rtl/rf_arb_starve_counter.sv
// rtl/rf_arb_starve_counter.sv - saturating count of consecutive ALU stall cycles
module rf_arb_starve_counter
    import rf_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic limit_hit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count;
    logic [STARVE_W-1:0] count_next;

    always_comb begin
        count_next = '0;
        if (stall) begin
            count_next = (count == LIMIT_V) ? count : count + STARVE_W'(1);
        end
    end

    // Flag reflects the post-update value so the FSM switches on the same edge.
    assign limit_hit = (count_next == LIMIT_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - two-requester register-file write port arbiter
module rf_writeback_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_addr_i,
    input  logic [XLEN-1:0]       alu_data_i,
    output logic                  alu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_addr_i,
    input  logic [XLEN-1:0]       lsu_data_i,
    output logic                  lsu_ready_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o,
    output logic [CNT_W-1:0]      conflict_cnt_o
);

    arb_state_e state;
    logic       alu_grant;
    logic       lsu_grant;
    logic       limit_hit;
    logic       do_write;
    wb_req_t    alu_req;
    wb_req_t    lsu_req;
    wb_req_t    win_req;

    assign alu_req = '{valid: alu_valid_i, addr: alu_addr_i, data: alu_data_i};
    assign lsu_req = '{valid: lsu_valid_i, addr: lsu_addr_i, data: lsu_data_i};

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!rst_i) begin
            if (state == PRIO_ALU) begin
                alu_grant = alu_req.valid;
                lsu_grant = lsu_req.valid && !alu_req.valid;
            end else begin
                lsu_grant = lsu_req.valid;
                alu_grant = alu_req.valid && !lsu_req.valid;
            end
        end
    end

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;

    assign win_req  = lsu_grant ? gate_req(lsu_grant, lsu_req) : gate_req(alu_grant, alu_req);
    // Register 0 is hardwired: the handshake completes but nothing is written.
    assign do_write = win_req.valid && (win_req.addr != '0);

    rf_arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk_i),
        .rst      (rst_i),
        .stall    (alu_valid_i && !alu_grant),
        .limit_hit(limit_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= PRIO_LSU;
            rf_we_o        <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
            conflict_cnt_o <= '0;
        end else begin
            // PRIO_ALU lasts one cycle: the ALU either transfers or has dropped valid.
            case (state)
                PRIO_LSU: if (limit_hit) state <= PRIO_ALU;
                PRIO_ALU: state <= PRIO_LSU;
                default:  state <= PRIO_LSU;
            endcase
            rf_we_o <= do_write;
            if (do_write) begin
                rf_waddr_o <= win_req.addr;
                rf_wdata_o <= win_req.data;
            end
            if (alu_valid_i && lsu_valid_i && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - scoreboard bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_i;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_addr, lsu_addr;
    logic [31:0] alu_data, lsu_data;

    logic        alu_ready, lsu_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] conflict_cnt;

    logic        alu_ready_b, lsu_ready_b, rf_we_b;
    logic [4:0]  rf_waddr_b;
    logic [31:0] rf_wdata_b;
    logic [3:0]  conflict_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned conf;
    } exp_t;

    exp_t exp_q[$];

    int          alu_wait;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int unsigned m_conf;
    bit          g_alu, g_lsu, o_alu, o_lsu;

    rf_writeback_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .conflict_cnt_o(conflict_cnt)
    );

    rf_writeback_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data), .alu_ready_o(alu_ready_b),
        .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready_b),
        .rf_we_o(rf_we_b), .rf_waddr_o(rf_waddr_b), .rf_wdata_o(rf_wdata_b), .conflict_cnt_o(conflict_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, got, want, $time);
        end
    endfunction

    function automatic int unsigned sat(int unsigned v, int unsigned m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [4:0] rnd_addr();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'($urandom_range(1, 3));
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic model_reset();
        alu_wait = 0;
        m_addr   = '0;
        m_data   = '0;
        m_conf   = 0;
        exp_q.delete();
    endtask

    // Called at posedge+1; evaluates one cycle and returns at the next posedge+1.
    task automatic tick();
        bit   alu_first;
        exp_t e;
        @(negedge clk);
        alu_first = (alu_wait >= LIMIT);
        g_lsu = lsu_valid && !(alu_first && alu_valid);
        g_alu = alu_valid && !g_lsu;
        o_alu = alu_ready;
        o_lsu = lsu_ready;
        chk("alu_ready", 64'(alu_ready), 64'(g_alu));
        chk("lsu_ready", 64'(lsu_ready), 64'(g_lsu));
        chk("alu_ready_b", 64'(alu_ready_b), 64'(g_alu));
        chk("lsu_ready_b", 64'(lsu_ready_b), 64'(g_lsu));
        alu_wait = (alu_valid && !g_alu) ? alu_wait + 1 : 0;
        e.we = 1'b0;
        if (g_alu && alu_addr != 5'd0) begin e.we = 1'b1; m_addr = alu_addr; m_data = alu_data; end
        if (g_lsu && lsu_addr != 5'd0) begin e.we = 1'b1; m_addr = lsu_addr; m_data = lsu_data; end
        if (alu_valid && lsu_valid) m_conf++;
        e.addr = m_addr;
        e.data = m_data;
        e.conf = m_conf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
        chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(0));
        chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(0));
        chk({tag, "_conflict"}, 64'(conflict_cnt), 64'(0));
        chk({tag, "_conflict_b"}, 64'(conflict_cnt_b), 64'(0));
        chk({tag, "_alu_ready"}, 64'(alu_ready), 64'(0));
        chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'(0));
    endtask

    // Called at posedge+1; reset rises mid-cycle and outputs must clear before any edge.
    task automatic mid_reset();
        #2 rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        chk("release_rf_we", 64'(rf_we), 64'(0));
    endtask

    task automatic new_alu(bit v);
        alu_valid = v;
        alu_addr  = 5'($urandom_range(1, 31));
        alu_data  = $urandom;
    endtask

    task automatic new_lsu(bit v);
        lsu_valid = v;
        lsu_addr  = 5'($urandom_range(1, 31));
        lsu_data  = $urandom;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", 64'(rf_we), 64'(e.we));
                chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
                chk("conflict_cnt", 64'(conflict_cnt), 64'(sat(e.conf, 65535)));
                chk("rf_we_b", 64'(rf_we_b), 64'(e.we));
                chk("rf_waddr_b", 64'(rf_waddr_b), 64'(e.addr));
                chk("rf_wdata_b", 64'(rf_wdata_b), 64'(e.data));
                chk("conflict_cnt_b", 64'(conflict_cnt_b), 64'(sat(e.conf, 15)));
            end
        end
    end

    initial begin : stimulus
        bit av[8];
        bit ar[8];
        int pa, pl;
        av = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ar = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rst_i = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1111_1111;
        lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h2222_2222;
        g_alu = 1'b0; g_lsu = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Single LSU write, then an ALU write to register 0.
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'hDEAD_BEEF;
        tick();
        chk("lsu_only_ready", 64'(o_lsu), 64'(1));
        chk("lsu_only_we", 64'(rf_we), 64'(1));
        chk("lsu_only_waddr", 64'(rf_waddr), 64'(3));
        chk("lsu_only_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234_5678;
        tick();
        chk("r0_alu_ready", 64'(o_alu), 64'(1));
        chk("r0_we", 64'(rf_we), 64'(0));
        chk("r0_waddr_hold", 64'(rf_waddr), 64'(3));
        chk("r0_wdata_hold", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
        alu_valid = 1'b0;
        tick();

        // Both pending across a mid-cycle reset, then continuous contention.
        new_alu(1'b1);
        new_lsu(1'b1);
        mid_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("contend_lsu_grant", 64'(o_lsu), 64'((i % 5) != 4));
            chk("contend_alu_grant", 64'(o_alu), 64'((i % 5) == 4));
            if (i == 5) chk("contend_conflict6", 64'(conflict_cnt), 64'(6));
            if (g_lsu) new_lsu(1'b1);
            if (g_alu) new_alu(1'b1);
        end
        chk("conflict20", 64'(conflict_cnt), 64'(20));
        chk("conflict_sat15", 64'(conflict_cnt_b), 64'(15));

        // ALU drops valid after two stalls; the starvation count must restart.
        new_alu(1'b1);
        new_lsu(1'b1);
        mid_reset();
        for (int c = 0; c < 8; c++) begin
            alu_valid = av[c];
            tick();
            chk("restart_alu_grant", 64'(o_alu), 64'(ar[c]));
            if (g_lsu) new_lsu(1'b1);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();

        // Randomized traffic with requesters holding until accepted.
        pa = 50;
        pl = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                pa = $urandom_range(10, 100);
                pl = $urandom_range(10, 100);
            end
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom_range(0, 99) < pa);
                alu_addr  = rnd_addr();
                alu_data  = $urandom;
            end
            if (!lsu_valid || g_lsu) begin
                lsu_valid = ($urandom_range(0, 99) < pl);
                lsu_addr  = rnd_addr();
                lsu_data  = $urandom;
            end
            if (i == 1500) mid_reset();
            tick();
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
RF_WRITEBACK_ARBITER -- requirements
Module: rf_writeback_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive ALU-stalled cycles before the ALU is forced ahead; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of conflict_cnt_o.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 alu_valid_i  in  1  ALU writeback request.
REQ-006 alu_addr_i  in  5  ALU destination register.
REQ-007 alu_data_i  in  32  ALU result.
REQ-008 alu_ready_o  out  1  ALU request accepted this cycle.
REQ-009 lsu_valid_i  in  1  LSU load-writeback request.
REQ-010 lsu_addr_i  in  5  LSU destination register.
REQ-011 lsu_data_i  in  32  load data.
REQ-012 lsu_ready_o  out  1  LSU request accepted this cycle.
REQ-013 rf_we_o  out  1  register-file write enable (registered).
REQ-014 rf_waddr_o  out  5  register-file write address (registered).
REQ-015 rf_wdata_o  out  32  register-file write data (registered).
REQ-016 conflict_cnt_o  out  CNT_W  saturating count of cycles with both requesters valid.

Function
REQ-017 Handshake: a transfer occurs when valid_i and ready_o are both high in the same cycle; valid, addr and data SHALL be held stable by the requester until the transfer.
REQ-018 ready_o SHALL be combinational from the current valid inputs and the arbiter state; at most one ready_o SHALL be high per cycle; ready_o SHALL never be high while the matching valid_i is low.
REQ-019 FSM states: PRIO_LSU (reset state) and PRIO_ALU.
REQ-020 PRIO_LSU: LSU granted if lsu_valid_i; otherwise ALU granted if alu_valid_i.
REQ-021 PRIO_ALU: ALU granted if alu_valid_i; otherwise LSU granted if lsu_valid_i.
REQ-022 Starvation counter (4 bits): increments each cycle alu_valid_i=1 and alu_ready_o=0, saturating at STARVE_LIMIT; clears on an ALU transfer or when alu_valid_i=0.
REQ-023 PRIO_LSU -> PRIO_ALU at the edge where the counter value after update equals STARVE_LIMIT.
REQ-024 PRIO_ALU -> PRIO_LSU at the edge after exactly one ALU transfer, or when alu_valid_i=0.
REQ-025 Latency: a transfer in cycle N SHALL produce rf_we_o=1 with the accepted addr/data in cycle N+1; a cycle without a transfer SHALL produce rf_we_o=0 in cycle N+1.
REQ-026 A transfer with addr=0 SHALL complete the handshake but SHALL drive rf_we_o=0 in cycle N+1.
REQ-027 rf_waddr_o and rf_wdata_o SHALL hold their last values when rf_we_o=0.
REQ-028 Sustained throughput: one write per cycle when any requester is continuously valid.
REQ-029 conflict_cnt_o SHALL increment by 1 each cycle both valid_i are high and saturate at all-ones.
REQ-030 Same destination from both requesters in consecutive cycles: writes SHALL occur in grant order; the later write wins.

Reset
REQ-031 Asserting rst_i SHALL immediately force: state PRIO_LSU, starvation counter 0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, conflict_cnt_o=0.
REQ-032 While rst_i is high, alu_ready_o and lsu_ready_o SHALL be 0; a request pending at reset SHALL NOT be written after reset release.
REQ-033 The first transfer SHALL be possible in the first cycle after rst_i deasserts.

Structure
REQ-034 Package rf_arb_pkg SHALL hold: arbiter state enum, REG_ADDR_W=5, XLEN=32, and the writeback-request struct {valid, addr, data}.
REQ-035 One sub-module, rf_arb_starve_counter, SHALL implement the saturating starvation counter and its limit flag; everything else SHALL be in the top module.

Verification
REQ-036 LSU only, addr 3, data 0xDEADBEEF -> lsu_ready_o=1 in cycle N; rf_we_o=1, waddr=3, wdata=0xDEADBEEF in cycle N+1.
REQ-037 Both valid continuously, STARVE_LIMIT=4 -> LSU granted 4 cycles, ALU granted on the 5th, LSU again on the 6th; conflict_cnt_o=6 after 6 cycles.
REQ-038 ALU write to addr 0, data 0x12345678 -> alu_ready_o=1; rf_we_o stays 0 in the next cycle.
REQ-039 rst_i asserted mid-cycle while both requesters are valid -> outputs 0 without waiting for a clock edge; no write after release; first grant after release goes to the LSU.
REQ-040 CNT_W=4, both valid for 20 cycles -> conflict_cnt_o saturates at 15.
REQ-041 ALU valid drops after 2 stalled cycles, then reasserts -> counter restarts from 0; ALU forced only after 4 further stalled cycles.
